// File: rtl/cfg_loop_sched_pkg.sv
// Shared types and width constants for the nested-loop task scheduler.
// The widths track the configuration register fields that feed the scheduler.
package cfg_loop_sched_pkg;

    localparam int LEN_W = 4;
    localparam int BLK_W = 5;
    localparam int FRM_W = 4;
    localparam int PAT_W = 4;
    localparam int LAY_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_LWAIT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/cfg_loop_odometer.sv
// Chained wrap counters (row innermost, then block, frame, patch).
// Each level wraps to zero at its bound and carries into the next level.
module loop_odometer #(
    parameter int LEN_W = cfg_loop_sched_pkg::LEN_W,
    parameter int BLK_W = cfg_loop_sched_pkg::BLK_W,
    parameter int FRM_W = cfg_loop_sched_pkg::FRM_W,
    parameter int PAT_W = cfg_loop_sched_pkg::PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic [LEN_W-1:0] bnd_row,
    input  logic [BLK_W-1:0] bnd_blk,
    input  logic [FRM_W-1:0] bnd_frm,
    input  logic [PAT_W-1:0] bnd_pat,
    output logic [LEN_W-1:0] idx_row,
    output logic [BLK_W-1:0] idx_blk,
    output logic [FRM_W-1:0] idx_frm,
    output logic [PAT_W-1:0] idx_pat,
    output logic [3:0]       wrap,
    output logic             all_wrap
);

    logic [LEN_W-1:0] row_r;
    logic [BLK_W-1:0] blk_r;
    logic [FRM_W-1:0] frm_r;
    logic [PAT_W-1:0] pat_r;
    logic [3:0]       wrap_s;

    // Level n wraps on the next advance only when every inner level also wraps.
    always_comb begin
        wrap_s    = 4'b0000;
        wrap_s[0] = (row_r == bnd_row);
        wrap_s[1] = wrap_s[0] && (blk_r == bnd_blk);
        wrap_s[2] = wrap_s[1] && (frm_r == bnd_frm);
        wrap_s[3] = wrap_s[2] && (pat_r == bnd_pat);
    end

    // Index registers: cleared on load, stepped once per accepted task.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r <= {LEN_W{1'b0}};
            blk_r <= {BLK_W{1'b0}};
            frm_r <= {FRM_W{1'b0}};
            pat_r <= {PAT_W{1'b0}};
        end else if (clr) begin
            row_r <= {LEN_W{1'b0}};
            blk_r <= {BLK_W{1'b0}};
            frm_r <= {FRM_W{1'b0}};
            pat_r <= {PAT_W{1'b0}};
        end else if (adv) begin
            row_r <= wrap_s[0] ? {LEN_W{1'b0}} : row_r + LEN_W'(1'b1);
            if (wrap_s[0]) begin
                blk_r <= wrap_s[1] ? {BLK_W{1'b0}} : blk_r + BLK_W'(1'b1);
            end
            if (wrap_s[1]) begin
                frm_r <= wrap_s[2] ? {FRM_W{1'b0}} : frm_r + FRM_W'(1'b1);
            end
            if (wrap_s[2]) begin
                pat_r <= wrap_s[3] ? {PAT_W{1'b0}} : pat_r + PAT_W'(1'b1);
            end
        end
    end

    assign idx_row  = row_r;
    assign idx_blk  = blk_r;
    assign idx_frm  = frm_r;
    assign idx_pat  = pat_r;
    assign wrap     = wrap_s;
    assign all_wrap = wrap_s[3];

endmodule

// File: rtl/cfg_loop_sched.sv
// Nested-loop row-task scheduler: latches loop bounds on start, issues one task
// per accepted handshake and waits for a datapath flush at each layer boundary.
module cfg_loop_sched #(
    parameter int LEN_W = cfg_loop_sched_pkg::LEN_W,
    parameter int BLK_W = cfg_loop_sched_pkg::BLK_W,
    parameter int FRM_W = cfg_loop_sched_pkg::FRM_W,
    parameter int PAT_W = cfg_loop_sched_pkg::PAT_W,
    parameter int LAY_W = cfg_loop_sched_pkg::LAY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len_row,
    input  logic [BLK_W-1:0] cfg_dep_blk,
    input  logic [BLK_W-1:0] cfg_num_blk,
    input  logic [FRM_W-1:0] cfg_num_frm,
    input  logic [PAT_W-1:0] cfg_num_pat,
    input  logic [LAY_W-1:0] cfg_num_lay,
    output logic             tsk_vld,
    input  logic             tsk_rdy,
    output logic [LEN_W-1:0] tsk_row,
    output logic [BLK_W-1:0] tsk_blk,
    output logic [FRM_W-1:0] tsk_frm,
    output logic [PAT_W-1:0] tsk_pat,
    output logic [LAY_W-1:0] tsk_lay,
    output logic [BLK_W-1:0] tsk_dep,
    output logic             tsk_first,
    output logic             tsk_last,
    output logic             lay_end,
    input  logic             lay_ack,
    output logic             busy,
    output logic             done
);
    import cfg_loop_sched_pkg::*;

    state_t           state_r, state_s;
    logic [LEN_W-1:0] len_r;
    logic [BLK_W-1:0] dep_r, blk_bnd_r;
    logic [FRM_W-1:0] frm_bnd_r;
    logic [PAT_W-1:0] pat_bnd_r;
    logic [LAY_W-1:0] lay_bnd_r, lay_r;
    logic [3:0]       wrap_s;
    logic             all_wrap_s, adv_s, clr_s, lay_inc_s, unused_s;

    assign adv_s    = (state_r == ST_RUN) && tsk_rdy;
    assign clr_s    = (state_r == ST_LOAD);
    assign unused_s = ^wrap_s[3:1];

    loop_odometer #(
        .LEN_W(LEN_W), .BLK_W(BLK_W), .FRM_W(FRM_W), .PAT_W(PAT_W)
    ) u_odo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .adv     (adv_s),
        .bnd_row (len_r),
        .bnd_blk (blk_bnd_r),
        .bnd_frm (frm_bnd_r),
        .bnd_pat (pat_bnd_r),
        .idx_row (tsk_row),
        .idx_blk (tsk_blk),
        .idx_frm (tsk_frm),
        .idx_pat (tsk_pat),
        .wrap    (wrap_s),
        .all_wrap(all_wrap_s)
    );

    // Next-state decode; lay_ack is only meaningful while waiting for the flush.
    always_comb begin
        state_s   = state_r;
        lay_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_IDLE;
            end
            ST_LOAD: state_s = ST_RUN;
            ST_RUN: begin
                if (tsk_rdy && all_wrap_s) state_s = ST_LWAIT;
                else                       state_s = ST_RUN;
            end
            ST_LWAIT: begin
                if (!lay_ack) begin
                    state_s = ST_LWAIT;
                end else if (lay_r == lay_bnd_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s   = ST_RUN;
                    lay_inc_s = 1'b1;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Shadow bounds and layer index; bounds are frozen for the whole run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r     <= {LEN_W{1'b0}};
            dep_r     <= {BLK_W{1'b0}};
            blk_bnd_r <= {BLK_W{1'b0}};
            frm_bnd_r <= {FRM_W{1'b0}};
            pat_bnd_r <= {PAT_W{1'b0}};
            lay_bnd_r <= {LAY_W{1'b0}};
            lay_r     <= {LAY_W{1'b0}};
        end else if (state_r == ST_LOAD) begin
            len_r     <= cfg_len_row;
            dep_r     <= cfg_dep_blk;
            blk_bnd_r <= cfg_num_blk;
            frm_bnd_r <= cfg_num_frm;
            pat_bnd_r <= cfg_num_pat;
            lay_bnd_r <= cfg_num_lay;
            lay_r     <= {LAY_W{1'b0}};
        end else if (lay_inc_s) begin
            lay_r <= lay_r + LAY_W'(1'b1);
        end
    end

    assign tsk_vld   = (state_r == ST_RUN);
    assign lay_end   = (state_r == ST_LWAIT);
    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign tsk_lay   = lay_r;
    assign tsk_dep   = dep_r;
    assign tsk_first = (tsk_row == {LEN_W{1'b0}});
    assign tsk_last  = wrap_s[0];

endmodule
